bit_recovery: RTL and testbench



---
 rtl/bit_recovery.sv | 143 ++++++++++++++
 tb/tb_bit_recovery.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_recovery.sv
// Purpose: UART receive front end. Synchronises the RX pin, finds start edges, majority-votes mid-bit samples.
// Latency: first strobe SYNC_STAGES+OVERSAMPLING+1 clock edges after the pin is first sampled low; then one per bit.
// Backpressure: none; one strobe every OVERSAMPLING clocks, and the consumer must take it on that cycle.
module bit_recovery #(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_pin_i,
    output logic rx_o,
    output logic valid_o,
    output logic busy_o
);

    localparam int PW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS + 2);
    localparam int M  = OVERSAMPLING / 2;

    localparam logic [PW-1:0] PH_LO   = PW'(M - 1);
    localparam logic [PW-1:0] PH_MID  = PW'(M);
    localparam logic [PW-1:0] PH_HI   = PW'(M + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLING - 1);

    // Index of the stop bit: start bit is 0 and data bits are 1..DATA_BITS.
    localparam logic [BW-1:0] STOP_IDX = BW'(DATA_BITS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t                 state;
    logic [PW-1:0]          phase;
    logic [BW-1:0]          bit_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   line;
    logic                   fall;
    logic                   s_lo;
    logic                   s_mid;
    logic                   s_hi;
    logic                   hi_smp;
    logic                   vote;

    // Metastability synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_pin_i};
        end
    end

    assign line = sync_q[SYNC_STAGES-1];

    // Edge history tracks the synchronised line every cycle regardless of state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= line;
        end
    end

    assign fall = prev_q & ~line;

    // When the last sample phase coincides with the decision phase (OVERSAMPLING = 4)
    // the third sample is taken straight from the line instead of its register.
    assign hi_smp = (phase == PH_HI) ? line : s_hi;
    assign vote   = (s_lo & s_mid) | (s_lo & hi_smp) | (s_mid & hi_smp);

    // Frame tracking FSM: phase/bit counting, sample capture, strobe and busy generation.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            s_lo    <= 1'b1;
            s_mid   <= 1'b1;
            s_hi    <= 1'b1;
            rx_o    <= 1'b0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (fall) begin
                        state   <= FRAME;
                        phase   <= '0;
                        bit_cnt <= '0;
                        busy_o  <= 1'b1;
                    end
                end

                FRAME: begin
                    phase <= phase + 1'b1;
                    if (phase == PH_LO) begin
                        s_lo <= line;
                    end
                    if (phase == PH_MID) begin
                        s_mid <= line;
                    end
                    if (phase == PH_HI) begin
                        s_hi <= line;
                    end
                    if (phase == PH_LAST) begin
                        if ((bit_cnt == '0) && vote) begin
                            // Start bit voted high: treat as a glitch and drop the frame silently.
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            valid_o <= 1'b1;
                            rx_o    <= ~vote;
                            if (bit_cnt == STOP_IDX) begin
                                if (fall) begin
                                    // Start edge coincides with the return to idle:
                                    // begin the next frame without losing a cycle.
                                    phase   <= '0;
                                    bit_cnt <= '0;
                                end else begin
                                    state  <= IDLE;
                                    busy_o <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_recovery.sv
// Bench for bit_recovery: drives UART frames on the raw pin and compares recovered strobes
// against a frame-level model (expected bit values and strobe cycles derived from the framing rules).
// Runs a fixed number of cycles; no unbounded waits.
module tb_bit_recovery;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int SS = 2;
    localparam int FIRST_LAT = SS + OS + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin = 1'b1;
    logic rx;
    logic vld;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   obs_cyc[$];
    logic obs_rx[$];
    logic obs_busy[$];
    int   exp_cyc[$];
    logic exp_rx[$];

    bit_recovery #(
        .OVERSAMPLING(OS),
        .DATA_BITS   (DB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .rx_pin_i(pin),
        .rx_o    (rx),
        .valid_o (vld),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe recorder, sampled shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (vld === 1'b1) begin
            obs_cyc.push_back(cyc);
            obs_rx.push_back(rx);
            obs_busy.push_back(busy);
        end
    end

    function automatic void clear_queues();
        obs_cyc.delete();
        obs_rx.delete();
        obs_busy.delete();
        exp_cyc.delete();
        exp_rx.delete();
    endfunction

    // Frame model: a start bit driven low at cycle t0 yields strobes at t0+FIRST_LAT+OS*k,
    // carrying the inverted line level of start, data (LSB first) and stop.
    function automatic void model_frame(input logic [7:0] d, input logic stop, input int t0);
        exp_rx.push_back(1'b1);
        exp_cyc.push_back(t0 + FIRST_LAT);
        for (int i = 0; i < DB; i++) begin
            exp_rx.push_back(~d[i]);
            exp_cyc.push_back(t0 + FIRST_LAT + OS * (i + 1));
        end
        exp_rx.push_back(~stop);
        exp_cyc.push_back(t0 + FIRST_LAT + OS * (DB + 1));
    endfunction

    task automatic hold(input logic b, input int n);
        pin = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        int t0;
        t0 = cyc;
        model_frame(d, stop, t0);
        hold(1'b0, OS);
        for (int i = 0; i < DB; i++) hold(d[i], OS);
        hold(stop, OS);
    endtask

    task automatic test_reset();
        checks++; if (rx !== 1'b0) begin errors++; $display("FAIL reset_rx got %b want 0", rx); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", vld); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        hold(1'b1, 5);
        clear_queues();
        // Frame 0x5A interrupted in the middle of bit index 4 (data bit 3).
        hold(1'b0, OS);
        hold(1'b0, OS);
        hold(1'b1, OS);
        hold(1'b0, OS);
        hold(1'b1, OS / 2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy got %b want 1", busy); end
        checks++; if (obs_cyc.size() !== 4) begin errors++; $display("FAIL midframe_strobes got %0d want 4", obs_cyc.size()); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL async_valid got %b want 0", vld); end
        pin = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
        repeat (100) @(negedge clk);
        checks++; if (obs_cyc.size() !== 0) begin errors++; $display("FAIL post_reset_strobes got %0d want 0", obs_cyc.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_frame_a5();
        hold(1'b1, 20);
        clear_queues();
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 20);
        checks++; if (obs_cyc.size() !== 10) begin errors++; $display("FAIL a5_count got %0d want 10", obs_cyc.size()); end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            checks++; if (obs_rx[k] !== exp_rx[k]) begin errors++; $display("FAIL a5_rx[%0d] got %b want %b", k, obs_rx[k], exp_rx[k]); end
            checks++; if (obs_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL a5_cycle[%0d] got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
        end
        if (obs_busy.size() == 10) begin
            checks++; if (obs_busy[0] !== 1'b1) begin errors++; $display("FAIL a5_busy_first got %b want 1", obs_busy[0]); end
            checks++; if (obs_busy[9] !== 1'b0) begin errors++; $display("FAIL a5_busy_last got %b want 0", obs_busy[9]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int busy_cnt;
        hold(1'b1, 20);
        clear_queues();
        busy_cnt = 0;
        pin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) pin = 1'b1;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (busy_cnt !== OS) begin errors++; $display("FAIL glitch_busy_cycles got %0d want %0d", busy_cnt, OS); end
        checks++; if (obs_cyc.size() !== 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", obs_cyc.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    endtask

    task automatic test_noise();
        int t0;
        hold(1'b1, 20);
        clear_queues();
        t0 = cyc;
        model_frame(8'h00, 1'b1, t0);
        hold(1'b0, OS * 4);
        hold(1'b0, 8);
        hold(1'b1, 1);
        hold(1'b0, OS - 9);
        hold(1'b0, OS * 4);
        hold(1'b1, OS);
        hold(1'b1, 20);
        checks++; if (obs_cyc.size() !== 10) begin errors++; $display("FAIL noise_count got %0d want 10", obs_cyc.size()); end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            checks++; if (obs_rx[k] !== exp_rx[k]) begin errors++; $display("FAIL noise_rx[%0d] got %b want %b", k, obs_rx[k], exp_rx[k]); end
            checks++; if (obs_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL noise_cycle[%0d] got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
        end
    endtask

    task automatic test_bad_stop();
        hold(1'b1, 20);
        clear_queues();
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 60);
        checks++; if (obs_cyc.size() !== 10) begin errors++; $display("FAIL badstop_count got %0d want 10", obs_cyc.size()); end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            checks++; if (obs_rx[k] !== exp_rx[k]) begin errors++; $display("FAIL badstop_rx[%0d] got %b want %b", k, obs_rx[k], exp_rx[k]); end
            checks++; if (obs_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL badstop_cycle[%0d] got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
        end
        clear_queues();
        hold(1'b1, 20);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 20);
        checks++; if (obs_cyc.size() !== 10) begin errors++; $display("FAIL recover_count got %0d want 10", obs_cyc.size()); end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            checks++; if (obs_rx[k] !== exp_rx[k]) begin errors++; $display("FAIL recover_rx[%0d] got %b want %b", k, obs_rx[k], exp_rx[k]); end
            checks++; if (obs_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL recover_cycle[%0d] got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
        end
    endtask

    task automatic test_back_to_back();
        hold(1'b1, 20);
        clear_queues();
        send_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 25);
        checks++; if (obs_cyc.size() !== 20) begin errors++; $display("FAIL b2b_count got %0d want 20", obs_cyc.size()); end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            checks++; if (obs_rx[k] !== exp_rx[k]) begin errors++; $display("FAIL b2b_rx[%0d] got %b want %b", k, obs_rx[k], exp_rx[k]); end
            checks++; if (obs_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
        end
        for (int k = 1; k < obs_cyc.size(); k++) begin
            checks++; if (obs_cyc[k] - obs_cyc[k-1] !== OS) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want %0d", k, obs_cyc[k] - obs_cyc[k-1], OS); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int gap;
        hold(1'b1, 20);
        clear_queues();
        for (int f = 0; f < 10; f++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            hold(1'b1, gap);
        end
        hold(1'b1, 30);
        checks++; if (obs_cyc.size() !== exp_cyc.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_cyc.size(), exp_cyc.size()); end
        for (int k = 0; k < exp_cyc.size() && k < obs_cyc.size(); k++) begin
            checks++; if (obs_rx[k] !== exp_rx[k]) begin errors++; $display("FAIL rand_rx[%0d] got %b want %b", k, obs_rx[k], exp_rx[k]); end
            checks++; if (obs_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL rand_cycle[%0d] got %0d want %0d", k, obs_cyc[k], exp_cyc[k]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        pin = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame_a5();
        test_glitch();
        test_noise();
        test_bad_stop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
